// File: rtl/osd_spi_rx.sv
// osd_spi_rx: SPI mode-0 slave, oversampled in the clk domain, feeding the OSD strobe/start/byte stream.
// Optional MISO reply path is built only when OSD_SPI_MISO_EN is defined.
module osd_spi_rx #(
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    output logic       data_out_strobe,
    output logic       data_out_start,
    output logic [7:0] data_out,
    output logic [9:0] byte_cnt
);
    typedef enum logic {IDLE, SHIFT} state_e;

    logic [2:0] csn_q;
    logic [2:0] sclk_q;
    logic [2:0] mosi_q;
    state_e     state_q;
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [2:0] bit_q;
    logic [2:0] bit_d;
    logic       first_q;
    logic       done_q;
    logic       strobe_q;
    logic       start_q;
    logic [7:0] dout_q;
    logic [9:0] idx_q;
    logic [9:0] idx_d;
    logic [9:0] bcnt_q;
    logic       csn_s;
    logic       csn_fall;
    logic       sclk_rise;
    logic       unused_ok;

    // Sync stages reset to 0 so a CSn held low across reset release never reads as a falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csn_q  <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            csn_q  <= {csn_q[1:0], spi_csn};
            sclk_q <= {sclk_q[1:0], spi_sclk};
            mosi_q <= {mosi_q[1:0], spi_mosi};
        end
    end

    assign csn_s     = csn_q[1];
    assign csn_fall  = ~csn_q[1] & csn_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sr_d      = {sr_q[6:0], mosi_q[1]};
    assign bit_d     = bit_q + 3'd1;
    assign idx_d     = idx_q + 10'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            start_q  <= 1'b0;
            dout_q   <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            strobe_q <= done_q;
            start_q  <= 1'b0;
            if (done_q) begin
                dout_q  <= sr_q;
                start_q <= first_q;
                first_q <= 1'b0;
                bcnt_q  <= idx_q;
                idx_q   <= idx_d;
            end
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (csn_s) begin
                        state_q <= IDLE;
                        bit_q   <= '0;
                    end else if (sclk_rise) begin
                        sr_q  <= sr_d;
                        bit_q <= bit_d;
                        if (bit_q == 3'd7) done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A falling CSn restarts the frame from any state, overriding the updates above.
            if (csn_fall) begin
                state_q <= SHIFT;
                bit_q   <= '0;
                first_q <= 1'b1;
                bcnt_q  <= '0;
                idx_q   <= '0;
            end
        end
    end

    assign data_out_strobe = strobe_q;
    assign data_out_start  = start_q;
    assign data_out        = dout_q;
    assign byte_cnt        = bcnt_q;

`ifdef OSD_SPI_MISO_EN
    logic [7:0] tx_q;
    logic       sclk_fall;

    assign sclk_fall = ~sclk_q[1] & sclk_q[2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_q <= '1;
        end else if (csn_fall) begin
            tx_q <= STATUS;
        end else if (state_q == IDLE || csn_s) begin
            tx_q <= '1;
        end else if (done_q) begin
            tx_q <= tx_data;
        // The 8th falling edge of each byte is skipped so the freshly loaded reply MSB stays on the pin.
        end else if (sclk_fall && bit_q != 3'd0) begin
            tx_q <= {tx_q[6:0], 1'b1};
        end
    end

    assign spi_miso = tx_q[7];
`else
    assign spi_miso = 1'b1;
`endif

    assign unused_ok = ^{mosi_q[2], tx_data, STATUS};

endmodule

// File: tb/tb_osd_spi_rx.sv
// Directed bench for osd_spi_rx: expected bytes queued as SPI stimulus is driven, checked at each strobe.
module tb_osd_spi_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       spi_csn;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_data;
    logic       data_out_strobe;
    logic       data_out_start;
    logic [7:0] data_out;
    logic [9:0] byte_cnt;

    osd_spi_rx #(.STATUS(8'hA5)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_csn         (spi_csn),
        .spi_sclk        (spi_sclk),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .tx_data         (tx_data),
        .data_out_strobe (data_out_strobe),
        .data_out_start  (data_out_start),
        .data_out        (data_out),
        .byte_cnt        (byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic [9:0] cnt;
        time        t_rise;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    logic       prev_strobe = 1'b0;
    time        t_rise = 0;
    logic [7:0] miso_sh = '0;
    logic [7:0] exp_miso0;
    logic [7:0] exp_miso1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SCLK = clk/8: MOSI set while SCLK is low, MISO captured at each rising edge.
    task automatic send_bits(input logic [7:0] b, input int unsigned n, input logic push,
                             input logic st, input logic [9:0] idx);
        logic [7:0] sh;
        exp_t e;
        sh = b;
        for (int unsigned i = 0; i < n; i++) begin
            spi_mosi = sh[7];
            sh = sh << 1;
            clk_wait(4);
            spi_sclk = 1'b1;
            t_rise = $time;
            miso_sh = {miso_sh[6:0], spi_miso};
            if (push && i == n - 1) begin
                e.data = b; e.start = st; e.cnt = idx; e.t_rise = t_rise;
                sb.push_back(e);
            end
            clk_wait(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic st, input logic [9:0] idx);
        send_bits(b, 8, 1'b1, st, idx);
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_high();
        clk_wait(4);
        spi_csn = 1'b1;
        clk_wait(4);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (data_out_strobe === 1'b1) begin
            check("strobe_not_back_to_back", 32'(prev_strobe), 32'd0);
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("data_out_start", 32'(data_out_start), 32'(e.start));
                check("byte_cnt", 32'(byte_cnt), 32'(e.cnt));
                // 4 clk edges after an SCLK edge driven at posedge+1, sampled at the following negedge.
                check("strobe_latency", 32'($time - e.t_rise), 32'd44);
            end
        end
        prev_strobe = (data_out_strobe === 1'b1);
    end

    initial begin
        #2000000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
`ifdef OSD_SPI_MISO_EN
        exp_miso0 = 8'hA5;
        exp_miso1 = 8'h3C;
`else
        exp_miso0 = 8'hFF;
        exp_miso1 = 8'hFF;
`endif
        reset = 1'b0; spi_csn = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; tx_data = 8'h3C;

        // Reset values
        clk_wait(4);
        @(negedge clk);
        check("rst_strobe", 32'(data_out_strobe), 32'd0);
        check("rst_start", 32'(data_out_start), 32'd0);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd1);
        clk_wait(1);
        reset = 1'b1;

        // Random SCLK/MOSI with CSn high: any strobe is flagged by the monitor
        for (int i = 0; i < 100; i++) begin
            spi_sclk = 1'($urandom_range(0, 1));
            spi_mosi = 1'($urandom_range(0, 1));
            clk_wait(1);
        end
        spi_sclk = 1'b0; spi_mosi = 1'b0;
        clk_wait(6);
        @(negedge clk);
        check("idle_data", 32'(data_out), 32'h00);
        check("idle_byte_cnt", 32'(byte_cnt), 32'd0);
        check("idle_miso", 32'(spi_miso), 32'd1);

        // Four-byte frame
        clk_wait(1);
        cs_low();
        send_byte(8'h02, 1'b1, 10'd0);
        send_byte(8'h05, 1'b0, 10'd1);
        send_byte(8'hFF, 1'b0, 10'd2);
        send_byte(8'h00, 1'b0, 10'd3);
        cs_high();
        clk_wait(8);
        @(negedge clk);
        check("frame4_drained", 32'(sb.size()), 32'd0);
        check("frame4_cnt_held", 32'(byte_cnt), 32'd3);
        check("frame4_data_held", 32'(data_out), 32'h00);

        // Back-to-back frames, CSn high for 4 clk between
        clk_wait(1);
        cs_low();
        send_byte(8'h01, 1'b1, 10'd0);
        send_byte(8'h01, 1'b0, 10'd1);
        cs_high();
        cs_low();
        send_byte(8'h01, 1'b1, 10'd0);
        send_byte(8'h01, 1'b0, 10'd1);
        cs_high();
        clk_wait(8);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // CSn rises after 5 bits of byte 2: partial byte discarded
        cs_low();
        send_byte(8'hA7, 1'b1, 10'd0);
        send_bits(8'h6B, 5, 1'b0, 1'b0, 10'd0);
        cs_high();
        clk_wait(8);
        check("abort_drained", 32'(sb.size()), 32'd0);
        cs_low();
        send_byte(8'h02, 1'b1, 10'd0);
        cs_high();
        clk_wait(8);
        check("abort_next_drained", 32'(sb.size()), 32'd0);

        // Reset pulse during bit 3 of the first byte, CSn held low for the rest of the frame
        cs_low();
        send_bits(8'h9C, 3, 1'b0, 1'b0, 10'd0);
        reset = 1'b0;
        clk_wait(1);
        reset = 1'b1;
        @(negedge clk);
        check("rstpulse_data", 32'(data_out), 32'h00);
        check("rstpulse_byte_cnt", 32'(byte_cnt), 32'd0);
        clk_wait(1);
        send_bits(8'h9C << 3, 5, 1'b0, 1'b0, 10'd0);
        send_bits(8'hC3, 8, 1'b0, 1'b0, 10'd0);
        cs_high();
        clk_wait(8);
        check("rstpulse_no_strobe_data", 32'(data_out), 32'h00);
        cs_low();
        send_byte(8'h5A, 1'b1, 10'd0);
        cs_high();
        clk_wait(8);
        check("rstpulse_drained", 32'(sb.size()), 32'd0);

        // MISO reply: STATUS during byte 0, tx_data during byte 1
        @(negedge clk);
        check("miso_before", 32'(spi_miso), 32'd1);
        clk_wait(1);
        cs_low();
        send_byte(8'h11, 1'b1, 10'd0);
        check("miso_byte0", 32'(miso_sh), 32'(exp_miso0));
        send_byte(8'h22, 1'b0, 10'd1);
        check("miso_byte1", 32'(miso_sh), 32'(exp_miso1));
        cs_high();
        @(negedge clk);
        check("miso_after", 32'(spi_miso), 32'd1);
        clk_wait(8);
        check("miso_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/osd_spi_rx.md
# osd_spi_rx

Synchronous SPI slave that receives the OSD command/data stream from the companion MCU and converts it into the strobe/start/byte stream consumed by the OSD renderer. It sits directly upstream of the OSD block. All SPI pins are oversampled in the system clock domain, so no second clock exists. Each chip-select frame becomes one command byte, flagged with start, followed by payload bytes.

## Interface
- `STATUS` — default 8'hA5 — byte returned on MISO during the first byte of every frame (MISO build only)
- `clk` in 1 — system clock; must be ≥ 4× SCLK frequency
- `reset` in 1 — synchronous, active-low reset
- `spi_csn` in 1 — chip select from MCU, active-low, asynchronous to `clk`
- `spi_sclk` in 1 — SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous
- `spi_mosi` in 1 — serial data in, MSB first
- `spi_miso` out 1 — serial data out, MSB first
- `tx_data` in 8 — reply byte shifted out on MISO for bytes 2..n of a frame
- `data_out_strobe` out 1 — one-`clk` pulse per completed byte
- `data_out_start` out 1 — high with the strobe for the first byte of a frame only
- `data_out` out 8 — received byte; valid while the strobe is high, held otherwise
- `byte_cnt` out 10 — index of the byte just strobed within the current frame

## Operation
- Synchronisers: each of `spi_csn`, `spi_sclk`, `spi_mosi` passes through 2 flip-flops plus a third history stage for edge detection. All three share the same latency, so their relative timing is preserved.
- The FSM has two states: IDLE and SHIFT.
  - IDLE → SHIFT on synced `spi_csn` falling. Actions: bit counter cleared, `first` flag set, `byte_cnt` cleared to 0.
  - SHIFT → IDLE on synced `spi_csn` high, from any bit position. A partial byte is discarded with no strobe, and the bit counter is cleared.
- In SHIFT, each synced SCLK rising edge shifts the synced MOSI into an 8-bit shift register (`{sr[6:0], mosi}`) and increments a 3-bit bit counter.
- When the counter wraps from 7 to 0:
  - The next cycle pulses `data_out_strobe` with `data_out` set to the assembled byte.
  - `data_out_start` = `first`. `first` is then cleared.
  - `byte_cnt` = index of that byte. It increments after each strobe (first byte = 0), wraps 1023 → 0, and is held in IDLE.
- An SCLK edge is counted only if synced `spi_csn` is low in the same cycle. A CSn rise coinciding with the 8th edge therefore produces no strobe.
- A new CSn falling edge always starts a fresh frame, even if no rise was seen, e.g. a glitch shorter than the synchroniser.

## Timing
- Reset (`reset`=0 at a `clk` edge): state IDLE, `data_out_strobe`=0, `data_out_start`=0, `data_out`=8'h00, `byte_cnt`=0, `spi_miso`=1, shift register and bit counter 0.
- Reset asserted mid-frame aborts the frame with no strobe. After release, the block waits for the next CSn falling edge. A frame already in progress at release is ignored until CSn goes high and then low again.
- Latency from a physical SCLK rising edge of bit 0 (LSB) to `data_out_strobe` is 4 `clk` cycles (3 sync/edge-detect stages + 1 output register).
- Strobes are at least 8×4 `clk` apart, because SCLK high and low must each last ≥ 2 `clk`. The consumer needs no backpressure; none is provided.
- `data_out_strobe` is never high for two consecutive cycles.

## Configuration
- `OSD_SPI_MISO_EN` defined:
  - A TX shift register drives `spi_miso` from its MSB.
  - On CSn falling it loads `STATUS`.
  - On each synced SCLK falling edge in SHIFT it shifts left, filling with 1.
  - At each completed byte (the strobe cycle) it loads `tx_data`, so the MCU reads `STATUS` during byte 0 and `tx_data` during bytes 1..n.
  - In IDLE, `spi_miso`=1.
- Not defined: no TX logic is built, `spi_miso` is tied to 1, and `tx_data`/`STATUS` are unused.

## Test plan
- Reset with `spi_csn`=1 → all outputs at their reset values; no strobe for 100 cycles of random SCLK/MOSI activity.
- Frame 8'h02, 8'h05, 8'hFF, 8'h00 at SCLK = clk/8 → 4 strobes with data 02, 05, FF, 00; start high only on 02; `byte_cnt` 0, 1, 2, 3.
- Two back-to-back frames (8'h01, 8'h01) with CSn high for 4 `clk` between them → 4 strobes; start high on the first byte of each frame.
- CSn rises after 5 bits of byte 2 of a frame → exactly 1 strobe; the next frame's first byte (8'h02) has start=1 and `byte_cnt`=0.
- `reset` pulsed low for 1 cycle during bit 3 of the first byte, with CSn staying low through the rest of the frame → no strobes until CSn toggles; then normal reception.
- With `OSD_SPI_MISO_EN`, `STATUS`=8'hA5, `tx_data`=8'h3C, 2-byte frame → MISO sampled on SCLK rising edges reads A5 then 3C; `spi_miso`=1 before and after the frame.
